// File: rtl/_skid_reg_pkg.sv
// Shared constants for the two-slot skid register.
// State encodings and the occupancy decode live here.
package _skid_reg_pkg;

    localparam int BIT_WIDTH = 8;

    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_BUSY  = 2'b01;
    localparam logic [1:0] SKID_FULL  = 2'b10;

    function automatic logic [1:0] occ_of(input logic [1:0] st);
        logic [1:0] occ;
        occ = 2'd0;
        case (st)
            SKID_BUSY: occ = 2'd1;
            SKID_FULL: occ = 2'd2;
            default:   occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/_skid_reg_slot.sv
// One storage slot: n-bit register with load enable.
// Instantiated twice by _skid_reg, once for the main slot and once for the skid slot.
module _skid_slot #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/_skid_reg.sv
// Two-slot skid register with a fully registered in_ready.
// Optional synchronous flush port when SKID_REG_FLUSH_EN is defined.
module _skid_reg
    import _skid_reg_pkg::*;
#(
    parameter int n = BIT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SKID_REG_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [1:0]   state;
    logic [1:0]   state_nx;
    logic         in_fire;
    logic         out_fire;
    logic         main_ld;
    logic         skid_ld;
    logic         flush_i;
    logic [n-1:0] main_d;
    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;

`ifdef SKID_REG_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        main_ld  = 1'b0;
        skid_ld  = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_nx = SKID_BUSY;
                    main_ld  = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (in_fire && out_fire) begin
                    main_ld  = 1'b1;
                end else if (in_fire) begin
                    state_nx = SKID_FULL;
                    skid_ld  = 1'b1;
                end else if (out_fire) begin
                    state_nx = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    state_nx = SKID_BUSY;
                    main_ld  = 1'b1;
                end
            end
            default: state_nx = SKID_EMPTY;
        endcase
        // flush drops both handshakes and any pending slot load
        if (flush_i) begin
            state_nx = SKID_EMPTY;
            main_ld  = 1'b0;
            skid_ld  = 1'b0;
        end
    end

    assign main_d = (state == SKID_FULL) ? skid_q : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (state_nx == SKID_BUSY) || (state_nx == SKID_FULL);
            in_ready  <= (state_nx != SKID_FULL);
        end
    end

    _skid_slot #(.n(n)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    _skid_slot #(.n(n)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (skid_ld),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_data  = main_q;
    assign occupancy = occ_of(state);

endmodule

// File: tb/tb__skid_reg.sv
// Directed and random bench for _skid_reg.
// Define SKID_REG_FLUSH_EN to include the flush scenario.
module tb__skid_reg;
    import _skid_reg_pkg::*;

    localparam int N = BIT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef SKID_REG_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    _skid_reg #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SKID_REG_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        out_ready = 1'b1;
        step();
        step();
        asserts++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        asserts++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_outs: got v=%b occ=%0d d=%h want 0/0/00",
                     out_valid, occupancy, out_data);
        end
        rst_n = 1'b1;
        step();
        asserts++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        step();
        asserts++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            fails++;
            $display("FAIL first_beat: got v=%b d=%h want 1/a5", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        asserts++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL first_drain: got v=%b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            in_data = N'(c + 1);
            asserts++;
            if (out_valid !== (c >= 1 && c <= 16)) begin
                fails++;
                $display("FAIL stream_valid[%0d]: got %b want %b", c, out_valid,
                         (c >= 1 && c <= 16));
            end
            if (c >= 1 && c <= 16) begin
                asserts++;
                if (out_data !== N'(c)) begin
                    fails++;
                    $display("FAIL stream_data[%0d]: got %h want %h", c, out_data, N'(c));
                end
            end
            asserts++;
            if (occupancy > 2'd1) begin
                fails++;
                $display("FAIL stream_occ[%0d]: got %0d want <=1", c, occupancy);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        asserts++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_full: got occ=%0d rdy=%b d=%h v=%b want 2/0/11/1",
                     occupancy, in_ready, out_data, out_valid);
        end
        in_data = 8'h33;
        step();
        asserts++;
        if (occupancy !== 2'd2 || out_data !== 8'h11) begin
            fails++;
            $display("FAIL stall_hold: got occ=%0d d=%h want 2/11", occupancy, out_data);
        end
        out_ready = 1'b1;
        step();
        asserts++;
        if (out_data !== 8'h22 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_second: got d=%h occ=%0d rdy=%b want 22/1/1",
                     out_data, occupancy, in_ready);
        end
        step();
        asserts++;
        if (out_data !== 8'h33 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_third: got d=%h v=%b want 33/1", out_data, out_valid);
        end
        in_valid = 1'b0;
        step();
        asserts++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain: got occ=%0d v=%b want 0/0", occupancy, out_valid);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] q[$];
        logic         hold;
        logic [N-1:0] hold_data;
        hold = 1'b0;
        hold_data = '0;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = N'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            asserts++;
            if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
                out_valid !== (q.size() != 0)) begin
                fails++;
                $display("FAIL rand_flags[%0d]: got occ=%0d rdy=%b v=%b want occ=%0d",
                         i, occupancy, in_ready, out_valid, q.size());
            end
            if (q.size() != 0) begin
                asserts++;
                if (out_data !== q[0]) begin
                    fails++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, q[0]);
                end
            end
            if (hold) begin
                asserts++;
                if (out_valid !== 1'b1 || out_data !== hold_data) begin
                    fails++;
                    $display("FAIL rand_stable[%0d]: got v=%b d=%h want 1/%h",
                             i, out_valid, out_data, hold_data);
                end
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
            hold = out_valid && !out_ready;
            hold_data = out_data;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        asserts++;
        if (occupancy !== 2'd0) begin
            fails++;
            $display("FAIL rand_drain: got occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h44;
        step();
        in_data = 8'h55;
        step();
        asserts++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL mid_pre: got occ=%0d want 2", occupancy);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: got v=%b occ=%0d rdy=%b d=%h want 0/0/0/00",
                     out_valid, occupancy, in_ready, out_data);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        asserts++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_after: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_data = 8'h66;
        step();
        asserts++;
        if (out_valid !== 1'b1 || out_data !== 8'h66) begin
            fails++;
            $display("FAIL mid_new: got v=%b d=%h want 1/66", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
    endtask

`ifdef SKID_REG_FLUSH_EN
    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        flush = 1'b1;
        in_data = 8'h77;
        out_ready = 1'b1;
        step();
        asserts++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_empty: got occ=%0d v=%b rdy=%b want 0/0/1",
                     occupancy, out_valid, in_ready);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        asserts++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL flush_discard: got v=%b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef SKID_REG_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
